// File: rtl/memrw_pkg.sv
// Shared constants and types for the memrw_master memory read/write master.
// Holds the default read latency and FIFO depth together with the legality
// check applied to any (RDLAT, FIFODEPTH) pair.
package memrw_pkg;

    localparam int RDLAT_DEF     = 3;
    localparam int FIFODEPTH_DEF = 4;
    localparam int RDLAT_MIN     = 1;
    localparam int RDLAT_MAX     = 8;
    localparam int STAT_W        = 16;

    // Operation presented on the memory port in the cycle after an accept
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } mem_op_e;

    // The FIFO must absorb every read that can be in flight plus one more,
    // otherwise a full FIFO could be overrun by the memory pipeline.
    function automatic bit cfg_legal(input int rdlat, input int depth);
        return (rdlat >= RDLAT_MIN) && (rdlat <= RDLAT_MAX) && (depth >= rdlat + 1);
    endfunction

endpackage

// File: rtl/memrw_rspfifo.sv
// Read-response FIFO for memrw_master. Head word is presented combinationally
// on dout (zero while empty); push and pop may occur in the same cycle,
// including when the FIFO is full.
module memrw_rspfifo #(
    parameter  int WIDTH = 80,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : store[rd_ptr];

    // Data storage: written on push, never reset (contents are qualified by cnt)
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/memrw_master.sv
// memrw_master: request/response front end for a single-port memory with a
// fixed read latency. Accepted requests drive the memory port for one cycle;
// read data is tracked through a valid shift register and buffered in order in
// a response FIFO. Flow control reserves a FIFO slot per outstanding read.
// Optional statistics counters are built only when MEMRW_MASTER_STAT_EN is
// defined; otherwise rd_cnt/wr_cnt are constant zero.
module memrw_master
    import memrw_pkg::*;
#(
    parameter int ADDRBIT   = 6,
    parameter int WIDTH     = 80,
    parameter int RDLAT     = RDLAT_DEF,
    parameter int FIFODEPTH = FIFODEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic               req_we,
    input  logic [ADDRBIT-1:0] req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [ADDRBIT-1:0] mem_a,
    output logic               mem_we,
    output logic               mem_re,
    output logic [WIDTH-1:0]   mem_di,
    input  logic [WIDTH-1:0]   mem_do,
    output logic               busy,
    output logic [STAT_W-1:0]  rd_cnt,
    output logic [STAT_W-1:0]  wr_cnt
);

    localparam int OST_W = $clog2(FIFODEPTH + 1);

    if (!cfg_legal(RDLAT, FIFODEPTH)) begin : g_bad_cfg
        $error("memrw_master: RDLAT must be 1..8 and FIFODEPTH >= RDLAT+1");
    end

    logic              req_acc;
    logic              rd_acc;
    logic              wr_acc;
    mem_op_e           mem_op_p0;
    logic [RDLAT-1:0]  rd_vld_p;
    logic [OST_W-1:0]  outstanding;
    logic              rsp_pop;
    logic              fifo_empty;
    logic [OST_W-1:0]  fifo_cnt_unused;

    assign req_acc = req_vld & req_rdy;
    assign rd_acc  = req_acc & ~req_we;
    assign wr_acc  = req_acc & req_we;

    assign mem_we  = (mem_op_p0 == OP_WR);
    assign mem_re  = (mem_op_p0 == OP_RD);

    // A slot is reserved from read accept until pop, so the FIFO cannot overflow.
    assign req_rdy = (outstanding < OST_W'(FIFODEPTH));
    assign busy    = (outstanding != '0);
    assign rsp_vld = ~fifo_empty;
    assign rsp_pop = rsp_vld & rsp_rdy;

    // Memory port: accepted request is presented for exactly one cycle, address/data hold otherwise
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_op_p0 <= OP_IDLE;
            mem_a     <= '0;
            mem_di    <= '0;
        end else if (req_acc) begin
            mem_op_p0 <= req_we ? OP_WR : OP_RD;
            mem_a     <= req_addr;
            mem_di    <= req_wdata;
        end else begin
            mem_op_p0 <= OP_IDLE;
        end
    end

    // Read valid pipeline: last stage marks the cycle in which mem_do holds read data
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_vld_p <= '0;
        end else begin
            rd_vld_p[0] <= mem_re;
            for (int i = 1; i < RDLAT; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
        end
    end

    // Outstanding reads: in flight plus buffered; accept and pop together cancel
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            outstanding <= '0;
        end else begin
            case ({rd_acc, rsp_pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    memrw_rspfifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (rd_vld_p[RDLAT-1]),
        .din   (mem_do),
        .pop   (rsp_pop),
        .dout  (rsp_data),
        .empty (fifo_empty),
        .cnt   (fifo_cnt_unused)
    );

`ifdef MEMRW_MASTER_STAT_EN
    logic [STAT_W-1:0] rd_cnt_q;
    logic [STAT_W-1:0] wr_cnt_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Accepted-request statistics, saturating at all ones
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_acc) begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (wr_acc) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: doc/memrw_master.md
MEMRW_MASTER -- requirements
Module: memrw_master

Interface
REQ-001 SHALL have parameter ADDRBIT, default 6: memory address width.
REQ-002 SHALL have parameter WIDTH, default 80: data width.
REQ-003 SHALL have parameter RDLAT, default 3: memory read latency in clk cycles, measured from the mem_re cycle to the cycle mem_do is valid; legal range 1..8.
REQ-004 SHALL have parameter FIFODEPTH, default 4: response FIFO depth; legal only if FIFODEPTH >= RDLAT+1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have ports req_vld (input, 1) and req_rdy (output, 1): request handshake.
REQ-008 SHALL have ports req_we (input, 1), req_addr (input, ADDRBIT) and req_wdata (input, WIDTH): request type, address and write data.
REQ-009 SHALL have ports rsp_vld (output, 1), rsp_rdy (input, 1) and rsp_data (output, WIDTH): read-response handshake and data.
REQ-010 SHALL have ports mem_a (output, ADDRBIT), mem_we (output, 1), mem_re (output, 1), mem_di (output, WIDTH) and mem_do (input, WIDTH): memory port.
REQ-011 SHALL have port busy, output, 1 bit: high while any read is in flight or buffered.
REQ-012 SHALL have ports rd_cnt and wr_cnt, output, 16 bits each: statistics counters.

Function
REQ-013 SHALL accept a request on a rising clk edge when req_vld & req_rdy.
REQ-014 SHALL register an accepted request onto mem_a, mem_we/mem_re and mem_di for exactly the following cycle; with no accept, mem_we=mem_re=0 and mem_a/mem_di hold their last values.
REQ-015 SHALL track reads with a RDLAT-stage valid shift register; the stage-RDLAT output pushes mem_do into the response FIFO on that edge.
REQ-016 SHALL present the FIFO head on rsp_data with rsp_vld = FIFO non-empty, and pop on rsp_vld & rsp_rdy.
REQ-017 SHALL give a minimum read latency of RDLAT+2 cycles from the accept edge to rsp_vld high.
REQ-018 SHALL keep an outstanding counter (in-flight reads + FIFO occupancy): +1 on read accept, -1 on pop, unchanged when both occur.
REQ-019 SHALL drive req_rdy = (outstanding < FIFODEPTH), applied to both reads and writes, so the FIFO never overflows.
REQ-020 SHALL return responses in request order; writes produce no response.
REQ-021 SHALL drive busy = (outstanding != 0).
REQ-022 SHALL hold rsp_data stable while rsp_vld=1 and rsp_rdy=0.
REQ-023 SHALL, when FIFO occupancy = FIFODEPTH-1 and a push and a pop occur in the same cycle, keep occupancy unchanged with no data loss.

Reset
REQ-024 SHALL, while rst_=0, clear req_rdy-gating state and drive: mem_a=0, mem_we=0, mem_re=0, mem_di=0, rsp_vld=0, rsp_data=0, busy=0, rd_cnt=0, wr_cnt=0, outstanding=0, shift register=0, FIFO empty.
REQ-025 SHALL discard in-flight reads and buffered responses on a reset asserted mid-operation; mem_do returning after reset release is ignored.
REQ-026 SHALL drive req_rdy=1 in the first cycle after reset release.

Configuration
REQ-027 SHALL implement rd_cnt and wr_cnt only when macro MEMRW_MASTER_STAT_EN is defined: +1 per accepted read or write, saturating at 16'hFFFF.
REQ-028 SHALL, without MEMRW_MASTER_STAT_EN, tie rd_cnt and wr_cnt to 0 with no counter flops.

Structure
REQ-029 SHALL place RDLAT and FIFODEPTH defaults, and the legal-range check constants, in shared package memrw_pkg.
REQ-030 SHALL implement the response FIFO as sub-module memrw_rspfifo (clk, rst_, push, din, pop, dout, empty, cnt).

Verification
REQ-031 SHALL cover: write addr 5 data 0xA5, then read addr 5 -> mem_we=1 with mem_a=5 one cycle after accept; read issues mem_re; rsp_data=0xA5 exactly RDLAT+2=5 cycles after the read accept.
REQ-032 SHALL cover: 6 back-to-back reads with rsp_rdy=0 -> req_rdy falls after the 4th accept, busy=1, and 4 responses are returned in order once rsp_rdy=1.
REQ-033 SHALL cover: continuous reads with rsp_rdy=1 -> one response per cycle, req_rdy never drops, and outstanding stays at or below 4.
REQ-034 SHALL cover: rst_ pulsed low with 2 reads in flight -> all outputs zero, with no rsp_vld after release despite mem_do activity.
REQ-035 SHALL cover: with MEMRW_MASTER_STAT_EN defined, 70000 reads -> rd_cnt=16'hFFFF; without the macro -> rd_cnt=0.
